// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: the occupancy state encoding and its width.
// Used by every elastic stage instance and by the hazard unit.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipeState_e;

  function automatic logic [OCC_W-1:0] occOf(input pipeState_e st);
    case (st)
      ST_EMPTY: occOf = 2'd0;
      ST_ONE:   occOf = 2'd1;
      ST_FULL:  occOf = 2'd2;
      default:  occOf = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One stage entry: control + data register with load and bubble-clear.
// Clear only rewrites the control lane; the data lane keeps its value.
module pipe_stage_slot #(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Load,
  input  logic              Clear,
  input  logic [CTRL_W-1:0] D_Ctrl,
  input  logic [DATA_W-1:0] D_Data,
  output logic [CTRL_W-1:0] Q_Ctrl,
  output logic [DATA_W-1:0] Q_Data
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Slot register; clear wins over load.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctrl_r <= CTRL_BUBBLE;
      data_r <= {DATA_W{1'b0}};
    end else if (Clear) begin
      ctrl_r <= CTRL_BUBBLE;
    end else if (Load) begin
      ctrl_r <= D_Ctrl;
      data_r <= D_Data;
    end
  end

  assign Q_Ctrl = ctrl_r;
  assign Q_Data = data_r;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid, flush-to-bubble.
// Define PIPE_STAGE_PERF_EN to add the saturating Stall_Cnt / Flush_Cnt outputs.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [OCC_W-1:0]  Occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt
`endif
);

  pipeState_e        state_r, nextState_s;
  logic              inReady_r, outValid_r;
  logic              inFire_s, outFire_s;
  logic              mainLoad_s, mainFromSkid_s, mainClear_s, skidLoad_s;
  logic [CTRL_W-1:0] mainCtrlD_s, skidCtrl_s;
  logic [DATA_W-1:0] mainDataD_s, skidData_s;

  assign inFire_s  = In_Valid & inReady_r;
  assign outFire_s = outValid_r & Out_Ready;

  // Next-state and slot-load decode.
  always_comb begin
    nextState_s    = state_r;
    mainLoad_s     = 1'b0;
    mainFromSkid_s = 1'b0;
    skidLoad_s     = 1'b0;
    if (Flush) begin
      nextState_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (inFire_s) begin
            nextState_s = ST_ONE;
            mainLoad_s  = 1'b1;
          end else begin
            nextState_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (inFire_s && outFire_s) begin
            mainLoad_s = 1'b1;
          end else if (outFire_s) begin
            nextState_s = ST_EMPTY;
          end else if (inFire_s) begin
            nextState_s = ST_FULL;
            skidLoad_s  = 1'b1;
          end else begin
            nextState_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (outFire_s) begin
            nextState_s    = ST_ONE;
            mainLoad_s     = 1'b1;
            mainFromSkid_s = 1'b1;
          end else begin
            nextState_s = ST_FULL;
          end
        end
        default: nextState_s = ST_EMPTY;
      endcase
    end
    // Going empty rewrites main ctrl to the bubble so Out_Ctrl needs no gating.
    mainClear_s = Flush | (nextState_s == ST_EMPTY);
  end

  // Main-slot source select: skid on drain from FULL, otherwise upstream.
  always_comb begin
    if (mainFromSkid_s) begin
      mainCtrlD_s = skidCtrl_s;
      mainDataD_s = skidData_s;
    end else begin
      mainCtrlD_s = In_Ctrl;
      mainDataD_s = In_Data;
    end
  end

  // State plus registered handshake outputs, all decoded from the next state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r    <= ST_EMPTY;
      inReady_r  <= 1'b0;
      outValid_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      inReady_r  <= (nextState_s != ST_FULL);
      outValid_r <= (nextState_s != ST_EMPTY);
    end
  end

  pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) uMain (
    .Clk(Clk), .Rst(Rst), .Load(mainLoad_s), .Clear(mainClear_s),
    .D_Ctrl(mainCtrlD_s), .D_Data(mainDataD_s), .Q_Ctrl(Out_Ctrl), .Q_Data(Out_Data)
  );

  pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) uSkid (
    .Clk(Clk), .Rst(Rst), .Load(skidLoad_s), .Clear(Flush),
    .D_Ctrl(In_Ctrl), .D_Data(In_Data), .Q_Ctrl(skidCtrl_s), .Q_Data(skidData_s)
  );

  assign In_Ready  = inReady_r;
  assign Out_Valid = outValid_r;
  assign Occupancy = occOf(state_r);

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stallCnt_r, flushCnt_r;

  // Saturating stall and flush event counters.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      if (In_Valid && !inReady_r && (stallCnt_r != {CNT_W{1'b1}})) begin
        stallCnt_r <= stallCnt_r + CNT_W'(1);
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if (Flush && (flushCnt_r != {CNT_W{1'b1}})) begin
        flushCnt_r <= flushCnt_r + CNT_W'(1);
      end else begin
        flushCnt_r <= flushCnt_r;
      end
    end
  end

  assign Stall_Cnt = stallCnt_r;
  assign Flush_Cnt = flushCnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: randomized traffic against a queue-based model.
// Define PIPE_STAGE_PERF_EN to also exercise the performance counters.
module tb_pipe_stage_elastic;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam logic [CW-1:0] BUB = 16'h00F0;

  logic          Clk, Rst, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [CW-1:0] In_Ctrl, Out_Ctrl;
  logic [DW-1:0] In_Data, Out_Data;
  logic [1:0]    Occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] Stall_Cnt, Flush_Cnt;
`endif

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(NW)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data), .Occupancy(Occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   rdyBlock;
  int   asserts;
  int   fails;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle, advance the FIFO model across the edge, sample #1 later.
  task automatic step(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input bit r, input bit f);
    bit   rdy, inF, outF;
    ent_t e;
    In_Valid  = v;
    In_Ctrl   = c;
    In_Data   = d;
    Out_Ready = r;
    Flush     = f;
    rdy  = !rdyBlock && (q.size() < 2);
    inF  = v && rdy;
    outF = (q.size() > 0) && r;
    @(posedge Clk);
    rdyBlock = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (outF) void'(q.pop_front());
      if (inF) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", Out_Valid); end
    asserts++; if (In_Ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b expected 0", In_Ready); end
    asserts++; if (Out_Ctrl !== BUB) begin fails++; $display("FAIL reset_ctrl: got %0h expected %0h", Out_Ctrl, BUB); end
    asserts++; if (Out_Data !== 64'd0) begin fails++; $display("FAIL reset_data: got %0h expected 0", Out_Data); end
    asserts++; if (Occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", Occupancy); end
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    asserts++; if (In_Ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %0b expected 0", In_Ready); end
    step(1'b0, 16'd0, 64'd0, 1'b1, 1'b0);
    asserts++; if (In_Ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %0b expected 1", In_Ready); end
  endtask

  task automatic test_streaming();
    logic [CW-1:0] c;
    for (int i = 1; i <= 8; i++) begin
      c = 16'($urandom);
      step(1'b1, c, 64'(i), 1'b1, 1'b0);
      asserts++; if (Out_Data !== 64'(i)) begin fails++; $display("FAIL stream_data: got %0h expected %0h", Out_Data, i); end
      asserts++; if (Out_Ctrl !== c) begin fails++; $display("FAIL stream_ctrl: got %0h expected %0h", Out_Ctrl, c); end
      asserts++; if (Occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ: got %0d expected 1", Occupancy); end
      asserts++; if (In_Ready !== 1'b1) begin fails++; $display("FAIL stream_ready: got %0b expected 1", In_Ready); end
    end
    step(1'b0, 16'd0, 64'd0, 1'b1, 1'b0);
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL stream_drain_valid: got %0b expected 0", Out_Valid); end
    asserts++; if (Out_Ctrl !== BUB) begin fails++; $display("FAIL stream_drain_ctrl: got %0h expected %0h", Out_Ctrl, BUB); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] dv [3];
    logic [DW-1:0] exp;
    dv[0] = 64'hA; dv[1] = 64'hB; dv[2] = 64'hC;
    step(1'b0, 16'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 16'h0011, dv[0], 1'b0, 1'b0);
    step(1'b1, 16'h0022, dv[1], 1'b0, 1'b0);
    asserts++; if (In_Ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %0b expected 0", In_Ready); end
    asserts++; if (Occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ: got %0d expected 2", Occupancy); end
    step(1'b1, 16'h0033, dv[2], 1'b0, 1'b0);
    asserts++; if (Occupancy !== 2'd2) begin fails++; $display("FAIL bp_hold_occ: got %0d expected 2", Occupancy); end
    asserts++; if (Out_Data !== dv[0]) begin fails++; $display("FAIL bp_head: got %0h expected %0h", Out_Data, dv[0]); end
    // Upstream keeps C valid until the stage takes it.
    for (int k = 1; k < 3; k++) begin
      step(1'b1, 16'h0033, dv[2], 1'b1, 1'b0);
      exp = dv[k];
      asserts++; if (Out_Data !== exp) begin fails++; $display("FAIL bp_order: got %0h expected %0h", Out_Data, exp); end
    end
    step(1'b0, 16'd0, 64'd0, 1'b1, 1'b0);
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %0b expected 0", Out_Valid); end
  endtask

  task automatic test_flush();
    step(1'b1, 16'h0101, 64'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h0202, 64'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h0303, 64'h3333, 1'b0, 1'b1);
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0b expected 0", Out_Valid); end
    asserts++; if (Out_Ctrl !== BUB) begin fails++; $display("FAIL flush_ctrl: got %0h expected %0h", Out_Ctrl, BUB); end
    asserts++; if (Occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d expected 0", Occupancy); end
    asserts++; if (In_Ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %0b expected 1", In_Ready); end
    step(1'b0, 16'd0, 64'd0, 1'b1, 1'b0);
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL flush_no_emit: got %0b expected 0", Out_Valid); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 16'h0A0A, 64'hAAAA, 1'b0, 1'b0);
    step(1'b1, 16'h0B0B, 64'hBBBB, 1'b0, 1'b0);
    #2;
    Rst = 1'b0;
    q.delete();
    rdyBlock = 1'b1;
    #1;
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0b expected 0", Out_Valid); end
    asserts++; if (Occupancy !== 2'd0) begin fails++; $display("FAIL rmid_occ: got %0d expected 0", Occupancy); end
    asserts++; if (In_Ready !== 1'b0) begin fails++; $display("FAIL rmid_ready: got %0b expected 0", In_Ready); end
    asserts++; if (Out_Ctrl !== BUB) begin fails++; $display("FAIL rmid_ctrl: got %0h expected %0h", Out_Ctrl, BUB); end
    asserts++; if (Out_Data !== 64'd0) begin fails++; $display("FAIL rmid_data: got %0h expected 0", Out_Data); end
    @(negedge Clk);
    Rst = 1'b1;
    step(1'b1, 16'h0D0D, 64'hDDDD, 1'b1, 1'b0);
    asserts++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL rmid_not_taken: got %0b expected 0", Out_Valid); end
    step(1'b1, 16'h0D0D, 64'hDDDD, 1'b1, 1'b0);
    asserts++; if (Out_Data !== 64'hDDDD) begin fails++; $display("FAIL rmid_first: got %0h expected dddd", Out_Data); end
    asserts++; if (Out_Valid !== 1'b1) begin fails++; $display("FAIL rmid_first_valid: got %0b expected 1", Out_Valid); end
    step(1'b0, 16'd0, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [CW-1:0] expCtrl;
    bit v, r, f;
    for (int i = 0; i < 100; i++) begin
      c = 16'($urandom);
      d = {$urandom, $urandom};
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 31) == 0);
      step(v, c, d, r, f);
      expCtrl = (q.size() > 0) ? q[0].c : BUB;
      asserts++; if (Occupancy > 2'd2) begin fails++; $display("FAIL rand_occ_bound: got %0d expected <=2", Occupancy); end
      asserts++; if (Occupancy !== 2'(q.size())) begin fails++; $display("FAIL rand_occ: got %0d expected %0d", Occupancy, q.size()); end
      asserts++; if (Out_Valid !== (q.size() > 0)) begin fails++; $display("FAIL rand_valid: got %0b expected %0b", Out_Valid, q.size() > 0); end
      asserts++; if (In_Ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_ready: got %0b expected %0b", In_Ready, q.size() < 2); end
      asserts++; if (Out_Ctrl !== expCtrl) begin fails++; $display("FAIL rand_ctrl: got %0h expected %0h", Out_Ctrl, expCtrl); end
      if (q.size() > 0) begin
        asserts++; if (Out_Data !== q[0].d) begin fails++; $display("FAIL rand_data: got %0h expected %0h", Out_Data, q[0].d); end
      end
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    @(negedge Clk);
    Rst = 1'b0;
    q.delete();
    rdyBlock = 1'b1;
    #2;
    Rst = 1'b1;
    step(1'b0, 16'd0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0001, 64'(i), 1'b0, 1'b0);
    asserts++; if (Stall_Cnt !== 4'd8) begin fails++; $display("FAIL perf_stall: got %0d expected 8", Stall_Cnt); end
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 64'd0, 1'b0, 1'b1);
    asserts++; if (Flush_Cnt !== 4'd3) begin fails++; $display("FAIL perf_flush: got %0d expected 3", Flush_Cnt); end
    asserts++; if (Stall_Cnt !== 4'd8) begin fails++; $display("FAIL perf_stall_hold: got %0d expected 8", Stall_Cnt); end
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0002, 64'(i), 1'b0, 1'b0);
    asserts++; if (Stall_Cnt !== 4'd15) begin fails++; $display("FAIL perf_sat: got %0d expected 15", Stall_Cnt); end
  endtask
`endif

  initial begin
    asserts   = 0;
    fails     = 0;
    rdyBlock  = 1'b1;
    Rst       = 1'b0;
    Flush     = 1'b0;
    In_Valid  = 1'b0;
    In_Ctrl   = 16'd0;
    In_Data   = 64'd0;
    Out_Ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
